// File: rtl/com_config_regs_bank.sv
// Configuration register bank sitting between the SW op-code decoder and the
// chip-configuration serialisers. Holds static words plus address-indexed
// arrays with optional shadow/commit double-buffering and burst writes.
//
// Handshake: every op_code_w_* input is a single-cycle, level-sampled strobe.
// There is no ready; a strobe is either accepted on the edge where it is high
// or rejected, and a rejection sets err_sticky. Holding a strobe for n cycles
// is n operations.
//
// The burst FSM has two states, so its state is visible directly on busy
// (busy == 1 <=> BURST).
module com_config_regs_bank #(
  parameter int N_STATIC  = 2,
  parameter int STATIC_W  = 24,
  parameter int N_ARRAY   = 3,
  parameter int DEPTH     = 256,
  parameter int WORD_W    = 16,
  parameter int SHADOW_EN = 1
) (
  input  logic                                     fw_clk_100,
  input  logic                                     fw_rst,
  input  logic                                     op_code_w_reset,
  input  logic [N_STATIC-1:0]                      op_code_w_static,
  input  logic [N_ARRAY-1:0]                       op_code_w_array,
  input  logic [N_ARRAY-1:0]                       op_code_w_burst,
  input  logic                                     op_code_w_data,
  input  logic                                     op_code_w_commit,
  input  logic [23:0]                              sw_write24_0,
  output logic [N_STATIC-1:0][STATIC_W-1:0]        w_cfg_static_reg,
  output logic [N_ARRAY-1:0][DEPTH-1:0][WORD_W-1:0] w_cfg_array_reg,
  output logic                                     busy,
  output logic                                     burst_done,
  output logic                                     err_sticky
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW     = (N_ARRAY > 1) ? $clog2(N_ARRAY) : 1;
  localparam int SW     = (N_STATIC > 1) ? $clog2(N_STATIC) : 1;
  localparam logic [8:0]  DEPTH9  = 9'(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e state_q, state_d;

  logic [N_STATIC-1:0][STATIC_W-1:0]         static_q, static_d;
  logic [N_ARRAY-1:0][DEPTH-1:0][WORD_W-1:0] shadow_q, shadow_d;
  logic [N_ARRAY-1:0][DEPTH-1:0][WORD_W-1:0] active_q, active_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [KW-1:0]     kidx_q, kidx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       rst_all;
  logic       any_static, any_array, any_burst;
  logic [2:0] n_cls;
  logic       win_commit, win_static, win_array, win_burst, win_data;
  logic       is_idle, addr_ok, cnt_ok;
  logic       do_commit, do_static, do_array, do_bstart, do_data;
  logic       err_evt;
  logic [7:0] addr_in;
  logic [15:0] cnt_in;
  logic [SW-1:0] sidx;
  logic [KW-1:0] aidx, bidx;
  logic          wr_en;
  logic [KW-1:0] wr_k;
  logic [ADDR_W-1:0] wr_a;

  function automatic logic [KW-1:0] arr_idx(input logic [N_ARRAY-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < N_ARRAY; i++) if (v[i]) r = KW'(i);
    return r;
  endfunction

  function automatic logic [SW-1:0] st_idx(input logic [N_STATIC-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < N_STATIC; i++) if (v[i]) r = SW'(i);
    return r;
  endfunction

  // Strobe decode: fixed priority, multi-hot and state legality checks.
  always_comb begin
    rst_all    = fw_rst | op_code_w_reset;
    addr_in    = sw_write24_0[23:16];
    cnt_in     = sw_write24_0[15:0];
    any_static = |op_code_w_static;
    any_array  = |op_code_w_array;
    any_burst  = |op_code_w_burst;
    n_cls      = {2'b00, op_code_w_commit} + {2'b00, any_static} + {2'b00, any_array}
               + {2'b00, any_burst} + {2'b00, op_code_w_data};
    win_commit = op_code_w_commit;
    win_static = any_static & ~op_code_w_commit;
    win_array  = any_array & ~any_static & ~op_code_w_commit;
    win_burst  = any_burst & ~any_array & ~any_static & ~op_code_w_commit;
    win_data   = op_code_w_data & ~any_burst & ~any_array & ~any_static & ~op_code_w_commit;
    is_idle    = (state_q == S_IDLE);
    addr_ok    = ({1'b0, addr_in} < DEPTH9);
    cnt_ok     = (cnt_in != 16'd0) && (cnt_in <= DEPTH16);
    sidx       = st_idx(op_code_w_static);
    aidx       = arr_idx(op_code_w_array);
    bidx       = arr_idx(op_code_w_burst);
    do_commit  = win_commit & is_idle;
    do_static  = win_static & $onehot(op_code_w_static);
    do_array   = win_array & $onehot(op_code_w_array) & is_idle & addr_ok;
    do_bstart  = win_burst & $onehot(op_code_w_burst) & is_idle & addr_ok & cnt_ok;
    do_data    = win_data & ~is_idle;
    err_evt    = (n_cls > 3'd1)
               | (win_commit & ~is_idle)
               | (win_static & ~do_static)
               | (win_array & ~do_array)
               | (win_burst & ~do_bstart)
               | (win_data & is_idle);
  end

  // FSM next state: enter BURST on an accepted start, leave on the last word.
  always_comb begin
    state_d = state_q;
    if (do_bstart) state_d = S_BURST;
    if (do_data && (cnt_q == 16'd1)) state_d = S_IDLE;
  end

  // FSM output: busy is the state itself.
  always_comb begin
    busy = (state_q == S_BURST);
  end

  // FSM state register; either reset source returns to IDLE.
  always_ff @(posedge fw_clk_100) begin
    if (rst_all) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath next values: one array write per cycle, commit copies shadows.
  always_comb begin
    static_d = static_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    kidx_d   = kidx_q;
    done_d   = 1'b0;
    err_d    = err_q | err_evt;
    wr_en    = do_array | do_data;
    wr_k     = do_data ? kidx_q : aidx;
    wr_a     = do_data ? ptr_q : addr_in[ADDR_W-1:0];
    if (do_static) static_d[sidx] = sw_write24_0[STATIC_W-1:0];
    if (wr_en) begin
      if (SHADOW_EN != 0) shadow_d[wr_k][wr_a] = sw_write24_0[WORD_W-1:0];
      else                active_d[wr_k][wr_a] = sw_write24_0[WORD_W-1:0];
    end
    if (do_bstart) begin
      ptr_d  = addr_in[ADDR_W-1:0];
      cnt_d  = cnt_in;
      kidx_d = bidx;
    end
    if (do_data) begin
      ptr_d  = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      cnt_d  = cnt_q - 16'd1;
      done_d = (cnt_q == 16'd1);
    end
    if (do_commit && (SHADOW_EN != 0)) active_d = shadow_q;
  end

  // Datapath registers; reset clears storage and status with no partial write.
  always_ff @(posedge fw_clk_100) begin
    if (rst_all) begin
      static_q <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      kidx_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      static_q <= static_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      kidx_q   <= kidx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign w_cfg_static_reg = static_q;
  assign w_cfg_array_reg  = active_q;
  assign burst_done       = done_q;
  assign err_sticky       = err_q;

endmodule

// File: tb/tb_com_config_regs_bank.sv
// Directed bench for com_config_regs_bank: a default instance (shadowed,
// DEPTH 256) and a second instance (no shadow, DEPTH 128) share stimulus.
module tb_com_config_regs_bank;

  logic        clk;
  logic        fw_rst;
  logic        op_code_w_reset;
  logic [1:0]  op_code_w_static;
  logic [2:0]  op_code_w_array;
  logic [2:0]  op_code_w_burst;
  logic        op_code_w_data;
  logic        op_code_w_commit;
  logic [23:0] sw_write24_0;

  logic [1:0][23:0]          st1, st2;
  logic [2:0][255:0][15:0]   arr1;
  logic [2:0][127:0][15:0]   arr2;
  logic busy1, done1, err1, busy2, done2, err2;

  logic [2:0][255:0][15:0] exp1;
  logic [2:0][127:0][15:0] exp2;

  int n_assert = 0;
  int n_fail   = 0;

  com_config_regs_bank dut1 (
    .fw_clk_100(clk), .fw_rst(fw_rst), .op_code_w_reset(op_code_w_reset),
    .op_code_w_static(op_code_w_static), .op_code_w_array(op_code_w_array),
    .op_code_w_burst(op_code_w_burst), .op_code_w_data(op_code_w_data),
    .op_code_w_commit(op_code_w_commit), .sw_write24_0(sw_write24_0),
    .w_cfg_static_reg(st1), .w_cfg_array_reg(arr1),
    .busy(busy1), .burst_done(done1), .err_sticky(err1)
  );

  com_config_regs_bank #(.DEPTH(128), .SHADOW_EN(0)) dut2 (
    .fw_clk_100(clk), .fw_rst(fw_rst), .op_code_w_reset(op_code_w_reset),
    .op_code_w_static(op_code_w_static), .op_code_w_array(op_code_w_array),
    .op_code_w_burst(op_code_w_burst), .op_code_w_data(op_code_w_data),
    .op_code_w_commit(op_code_w_commit), .sw_write24_0(sw_write24_0),
    .w_cfg_static_reg(st2), .w_cfg_array_reg(arr2),
    .busy(busy2), .burst_done(done2), .err_sticky(err2)
  );

  // Clock: 100 MHz.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arr1(input string tag);
    n_assert++;
    assert (arr1 === exp1) else begin
      n_fail++;
      $error("FAIL %s: dut1 active arrays differ from expected image", tag);
    end
  endtask

  task automatic chk_arr2(input string tag);
    n_assert++;
    assert (arr2 === exp2) else begin
      n_fail++;
      $error("FAIL %s: dut2 active arrays differ from expected image", tag);
    end
  endtask

  // Drive one cycle of strobes from a negedge, then return to idle inputs.
  task automatic drive(input logic rst, input logic [1:0] st, input logic [2:0] ar,
                       input logic [2:0] bu, input logic da, input logic cm,
                       input logic [23:0] pl);
    op_code_w_reset  = rst;
    op_code_w_static = st;
    op_code_w_array  = ar;
    op_code_w_burst  = bu;
    op_code_w_data   = da;
    op_code_w_commit = cm;
    sw_write24_0     = pl;
    @(negedge clk);
    op_code_w_reset  = 1'b0;
    op_code_w_static = '0;
    op_code_w_array  = '0;
    op_code_w_burst  = '0;
    op_code_w_data   = 1'b0;
    op_code_w_commit = 1'b0;
    sw_write24_0     = '0;
  endtask

  task automatic s_static(input int i, input logic [23:0] pl);
    drive(1'b0, 2'(1 << i), 3'b0, 3'b0, 1'b0, 1'b0, pl);
  endtask
  task automatic s_array(input int k, input logic [23:0] pl);
    drive(1'b0, 2'b0, 3'(1 << k), 3'b0, 1'b0, 1'b0, pl);
  endtask
  task automatic s_burst(input int k, input logic [7:0] a, input logic [15:0] c);
    drive(1'b0, 2'b0, 3'b0, 3'(1 << k), 1'b0, 1'b0, {a, c});
  endtask
  task automatic s_data(input logic [15:0] d);
    drive(1'b0, 2'b0, 3'b0, 3'b0, 1'b1, 1'b0, {8'h00, d});
  endtask
  task automatic s_commit();
    drive(1'b0, 2'b0, 3'b0, 3'b0, 1'b0, 1'b1, 24'h0);
  endtask
  task automatic s_oreset();
    drive(1'b1, 2'b0, 3'b0, 3'b0, 1'b0, 1'b0, 24'h0);
    exp1 = '0;
    exp2 = '0;
  endtask

  initial begin
    fw_rst = 1'b1;
    op_code_w_reset = 1'b0; op_code_w_static = '0; op_code_w_array = '0;
    op_code_w_burst = '0; op_code_w_data = 1'b0; op_code_w_commit = 1'b0;
    sw_write24_0 = '0;
    exp1 = '0;
    exp2 = '0;
    repeat (3) @(negedge clk);
    fw_rst = 1'b0;

    // Reset state
    chk("rst_static", {8'h0, st1[0] | st1[1]}, 32'h0);
    chk_arr1("rst_arrays");
    chk("rst_busy", {31'h0, busy1}, 32'h0);
    chk("rst_done", {31'h0, done1}, 32'h0);
    chk("rst_err", {31'h0, err1}, 32'h0);

    // Static write
    s_static(1, 24'hABCDEF);
    chk("static1", {8'h0, st1[1]}, 32'hABCDEF);
    chk("static0_untouched", {8'h0, st1[0]}, 32'h0);

    // Single array write is held in shadow until commit
    s_array(2, 24'h051234);
    chk("arr2_5_precommit", {16'h0, arr1[2][5]}, 32'h0);
    s_commit();
    exp1[2][5] = 16'h1234;
    chk("arr2_5_commit", {16'h0, arr1[2][5]}, 32'h1234);
    chk_arr1("arrays_after_commit");
    chk("err_clean1", {31'h0, err1}, 32'h0);

    // Wrapping burst: 0xFE, 0xFF, 0x00, 0x01
    s_burst(0, 8'hFE, 16'd4);
    chk("burst_busy", {31'h0, busy1}, 32'h1);
    s_data(16'd1);
    s_data(16'd2);
    s_data(16'd3);
    chk("burst_nodone_early", {31'h0, done1}, 32'h0);
    s_data(16'd4);
    chk("burst_done_pulse", {31'h0, done1}, 32'h1);
    chk("burst_busy_end", {31'h0, busy1}, 32'h0);
    @(negedge clk);
    chk("burst_done_one_cycle", {31'h0, done1}, 32'h0);
    chk_arr1("burst_in_shadow_only");
    s_commit();
    exp1[0][8'hFE] = 16'd1; exp1[0][8'hFF] = 16'd2;
    exp1[0][8'h00] = 16'd3; exp1[0][8'h01] = 16'd4;
    chk("burst_fe", {16'h0, arr1[0][8'hFE]}, 32'd1);
    chk("burst_01", {16'h0, arr1[0][8'h01]}, 32'd4);
    chk_arr1("burst_committed");
    chk("err_clean2", {31'h0, err1}, 32'h0);

    // Burst aborted by op-code reset
    s_burst(1, 8'h10, 16'd3);
    s_data(16'hAA);
    s_data(16'hBB);
    chk("abort_busy_before", {31'h0, busy1}, 32'h1);
    s_oreset();
    chk("abort_busy", {31'h0, busy1}, 32'h0);
    chk("abort_done", {31'h0, done1}, 32'h0);
    chk("abort_static", {8'h0, st1[0] | st1[1]}, 32'h0);
    chk_arr1("abort_arrays");
    @(negedge clk);
    chk("abort_no_late_done", {31'h0, done1}, 32'h0);
    s_array(1, 24'h207777);
    s_commit();
    exp1[1][8'h20] = 16'h7777;
    chk("post_abort_write", {16'h0, arr1[1][8'h20]}, 32'h7777);
    chk("post_abort_err", {31'h0, err1}, 32'h0);

    // Data strobe in IDLE
    s_data(16'h5555);
    s_commit();
    chk("data_idle_err", {31'h0, err1}, 32'h1);
    chk_arr1("data_idle_storage");

    // Commit during BURST is rejected; burst continues
    s_oreset();
    chk("oreset_err_clear", {31'h0, err1}, 32'h0);
    s_burst(2, 8'h00, 16'd2);
    s_data(16'h11);
    s_commit();
    chk("commit_in_burst_err", {31'h0, err1}, 32'h1);
    chk("commit_in_burst_busy", {31'h0, busy1}, 32'h1);
    chk_arr1("commit_in_burst_storage");
    s_data(16'h22);
    chk("commit_in_burst_done", {31'h0, done1}, 32'h1);
    s_commit();
    exp1[2][0] = 16'h11; exp1[2][1] = 16'h22;
    chk_arr1("burst_after_rejected_commit");

    // Burst count 0
    s_oreset();
    s_burst(0, 8'h03, 16'd0);
    chk("cnt0_busy", {31'h0, busy1}, 32'h0);
    chk("cnt0_err", {31'h0, err1}, 32'h1);
    s_data(16'h9);
    s_commit();
    chk_arr1("cnt0_storage");

    // Multi-hot static vector ignored
    s_oreset();
    drive(1'b0, 2'b11, 3'b0, 3'b0, 1'b0, 1'b0, 24'h000123);
    chk("multihot_static", {8'h0, st1[0] | st1[1]}, 32'h0);
    chk("multihot_err", {31'h0, err1}, 32'h1);

    // Static beats array in the same cycle; the array write is dropped
    s_oreset();
    drive(1'b0, 2'b01, 3'b001, 3'b0, 1'b0, 1'b0, 24'h030055);
    s_commit();
    chk("prio_static", {8'h0, st1[0]}, 32'h030055);
    chk("prio_err", {31'h0, err1}, 32'h1);
    chk_arr1("prio_no_array_write");

    // DEPTH 128 unshadowed instance: direct writes and range check
    s_oreset();
    s_array(0, 24'h7F0099);
    exp2[0][127] = 16'h0099;
    chk("d128_direct_write", {16'h0, arr2[0][127]}, 32'h99);
    chk("d128_err_clean", {31'h0, err2}, 32'h0);
    chk_arr1("d256_shadow_not_active");
    s_array(0, 24'h800042);
    chk("d128_addr80_err", {31'h0, err2}, 32'h1);
    chk_arr2("d128_addr80_storage");
    chk("d256_addr80_ok", {31'h0, err1}, 32'h0);
    s_commit();
    chk_arr2("d128_commit_noop");
    exp1[0][127] = 16'h0099; exp1[0][128] = 16'h0042;
    chk_arr1("d256_commit_both");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
